// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id.sv
// IF/ID pipeline register: squash beats hold, hold beats load.
`timescale 1ns/1ps
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic        squash,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (squash) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!hold && load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc4_d   = pc4_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/FETCH/HOLD sequencing and IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
`timescale 1ns/1ps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        fetch_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;

  logic         ifid_load;
  logic         ifid_squash;
  logic [31:0]  ifid_instr_in;
  logic [31:0]  ifid_pc4_in;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    ifid_load     = 1'b0;
    ifid_squash   = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_q + PC_STEP;

    if (redirect) begin
      pc_d         = word_align(redirect_pc);
      ifid_squash  = 1'b1;
      hold_instr_d = NOP_INSTR;
      state_d      = (state_q == ST_BOOT) ? ST_BOOT : ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + PC_STEP;
            if (stall) begin
              hold_instr_d = imem_rdata;
              state_d      = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!stall) begin
            // No word this cycle: present a bubble so the decoder never sees a repeat.
            ifid_squash = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_instr_in = hold_instr_q;
            ifid_pc4_in   = pc_q;
            state_d       = ST_FETCH;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`else
  logic unused_target_low_bits;
  assign unused_target_low_bits = ^redirect_pc[1:0];
  assign fetch_misalign         = 1'b0;
`endif

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .hold     (stall),
    .squash   (ifid_squash),
    .instr_in (ifid_instr_in),
    .pc4_in   (ifid_pc4_in),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4)
  );

  assign imem_req  = (state_q == ST_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign opcode    = if_id_valid ? if_id_instr[31:26] : 6'd0;
  assign func      = if_id_valid ? if_id_instr[5:0]   : 6'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, if_id_valid, fetch_misalign;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4;
  logic [5:0]  opcode, func;

  logic        w_req, w_valid, w_misalign;
  logic [31:0] w_addr, w_instr, w_pc4;
  logic [5:0]  w_opcode, w_func;

  int tests_run;
  int tests_failed;

  // Behavioural model of the fetch stage as seen from outside.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_pend_instr;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_mis;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .opcode(opcode),
    .func(func), .fetch_misalign(fetch_misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_id_valid(w_valid),
    .if_id_instr(w_instr), .if_id_pc4(w_pc4), .opcode(w_opcode),
    .func(w_func), .fetch_misalign(w_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic drive(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_ready  = rdy;
    imem_rdata  = rdy ? mem_word(m_pc) : $urandom;
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_boot = 1; m_pend = 0; m_pend_instr = 0;
      m_valid = 0; m_instr = 0; m_pc4 = 0; m_mis = 0;
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'h3;
      m_valid = 0; m_instr = 0; m_pend = 0;
      if (ALIGN_EN && redirect_pc[1:0] != 2'b00) m_mis = 1;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_pend) begin
      if (!stall) begin
        m_valid = 1; m_instr = m_pend_instr; m_pc4 = m_pc; m_pend = 0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_pend = 1; m_pend_instr = imem_rdata;
      end else begin
        m_valid = 1; m_instr = imem_rdata; m_pc4 = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 0; m_instr = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 32'h0, 1);
    tick(); tick();
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", if_id_valid); end
    tests_run++; if (if_id_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000000", if_id_instr); end
    tests_run++; if (if_id_pc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc4: got %h want 00000000", if_id_pc4); end
    tests_run++; if (fetch_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign: got %0b want 0", fetch_misalign); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_boot();
    rst = 0;
    drive(0, 0, 32'h0, 1);
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL boot_req: got %0b want 0", imem_req); end
    tick();
    drive(0, 0, 32'h0, 1);
    #1;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL boot_first_fetch: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    tick();
    tests_run++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2008_0005) begin tests_failed++; $display("FAIL boot_instr: got v=%0b %h want v=1 20080005", if_id_valid, if_id_instr); end
    tests_run++; if (if_id_pc4 !== 32'h4) begin tests_failed++; $display("FAIL boot_pc4: got %h want 00000004", if_id_pc4); end
    tests_run++; if (opcode !== 6'h08 || func !== 6'h05) begin tests_failed++; $display("FAIL boot_decode: got op=%h fn=%h want op=08 fn=05", opcode, func); end
    $display("[TB] test_boot done");
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, i == 2);
      #1;
      tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin tests_failed++; $display("FAIL wait_addr[%0d]: got req=%0b addr=%h want req=1 addr=00000004", i, imem_req, imem_addr); end
      tick();
      if (i < 2) begin
        tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_bubble[%0d]: got v=%0b want 0", i, if_id_valid); end
      end
    end
    tests_run++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h4) || if_id_pc4 !== 32'h8) begin tests_failed++; $display("FAIL wait_load: got v=%0b %h pc4=%h want v=1 %h pc4=00000008", if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h4)); end
    $display("[TB] test_wait_states done");
  endtask

  task automatic test_stall();
    drive(1, 0, 32'h0, 1);
    #1;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin tests_failed++; $display("FAIL stall_addr: got req=%0b addr=%h want req=1 addr=00000008", imem_req, imem_addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h4) || if_id_pc4 !== 32'h8) begin tests_failed++; $display("FAIL stall_keep[%0d]: got v=%0b %h pc4=%h want v=1 %h pc4=00000008", i, if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h4)); end
      drive(i < 2, 0, 32'h0, 1);
      #1;
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL hold_req[%0d]: got %0b want 0", i, imem_req); end
      tick();
    end
    tests_run++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h8) || if_id_pc4 !== 32'hC) begin tests_failed++; $display("FAIL stall_release: got v=%0b %h pc4=%h want v=1 %h pc4=0000000c", if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h8)); end
    drive(0, 0, 32'h0, 0);
    #1;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin tests_failed++; $display("FAIL stall_next_addr: got req=%0b addr=%h want req=1 addr=0000000c", imem_req, imem_addr); end
    tick();
    tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL no_duplicate: got v=%0b want 0", if_id_valid); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_redirect();
    drive(1, 1, 32'h40, 1);
    tick();
    tests_run++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || opcode !== 6'h0) begin tests_failed++; $display("FAIL redirect_squash: got v=%0b %h op=%h want v=0 00000000 op=00", if_id_valid, if_id_instr, opcode); end
    drive(0, 0, 32'h0, 0);
    #1;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin tests_failed++; $display("FAIL redirect_addr: got req=%0b addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
    tick();
    $display("[TB] test_redirect done");
  endtask

  task automatic test_misalign();
    drive(0, 1, 32'h42, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    #1;
    tests_run++; if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL misalign_addr: got %h want 00000040", imem_addr); end
    tests_run++; if (fetch_misalign !== ALIGN_EN) begin tests_failed++; $display("FAIL misalign_flag: got %0b want %0b", fetch_misalign, ALIGN_EN); end
    tick();
    drive(0, 1, 32'h80, 0);
    tick();
    tests_run++; if (fetch_misalign !== ALIGN_EN) begin tests_failed++; $display("FAIL misalign_sticky: got %0b want %0b", fetch_misalign, ALIGN_EN); end
    $display("[TB] test_misalign done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'h0, 1);
      tick();
      tests_run++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h80 + 4 * i) || if_id_pc4 !== 32'h84 + 4 * i) begin tests_failed++; $display("FAIL b2b[%0d]: got v=%0b %h pc4=%h want v=1 %h pc4=%h", i, if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h80 + 4 * i), 32'h84 + 4 * i); end
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 0, 32'h0, 1);
    tick();
    rst = 1;
    drive(1, 0, 32'h0, 1);
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_req: got %0b want 0", imem_req); end
    tick();
    rst = 0;
    drive(0, 0, 32'h0, 1);
    #1;
    tests_run++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_boot: got req=%0b addr=%h want req=0 addr=00000000", imem_req, imem_addr); end
    tick();
    tests_run++; if (if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_word: got v=%0b want 0", if_id_valid); end
    drive(0, 0, 32'h0, 1);
    tick();
    tests_run++; if (if_id_instr !== 32'h2008_0005 || if_id_pc4 !== 32'h4) begin tests_failed++; $display("FAIL rst_mid_refetch: got %h pc4=%h want 20080005 pc4=00000004", if_id_instr, if_id_pc4); end
    $display("[TB] test_reset_mid_hold done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
    rst = 1;
    drive(0, 0, 32'h0, 1);
    tick();
    rst = 0;
    drive(0, 0, 32'h0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 1);
      #1;
      tests_run++; if (w_req !== 1'b1 || w_addr !== exp_addr[i]) begin tests_failed++; $display("FAIL wrap_addr[%0d]: got req=%0b addr=%h want req=1 addr=%h", i, w_req, w_addr, exp_addr[i]); end
      tick();
    end
    tests_run++; if (w_pc4 !== 32'h4 || w_misalign !== 1'b0) begin tests_failed++; $display("FAIL wrap_pc4: got %h mis=%0b want 00000004 mis=0", w_pc4, w_misalign); end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rst = 1;
    drive(0, 0, 32'h0, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rp;
      rst = ($urandom_range(0, 199) == 0);
      rp = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rp, $urandom_range(0, 2) != 0);
      #1;
      tests_run++;
      if (imem_req !== (!rst && !m_boot && !m_pend) || imem_addr !== m_pc ||
          if_id_valid !== m_valid || if_id_instr !== m_instr ||
          (m_valid && if_id_pc4 !== m_pc4) ||
          opcode !== (m_valid ? m_instr[31:26] : 6'd0) ||
          func !== (m_valid ? m_instr[5:0] : 6'd0) ||
          fetch_misalign !== m_mis) begin
        tests_failed++;
        if (errs < 10) $display("FAIL random[%0d]: got req=%0b addr=%h v=%0b ins=%h pc4=%h mis=%0b want req=%0b addr=%h v=%0b ins=%h pc4=%h mis=%0b",
          n, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, fetch_misalign,
          (!rst && !m_boot && !m_pend), m_pc, m_valid, m_instr, m_pc4, m_mis);
        errs++;
      end
      tick();
    end
    rst = 0;
    $display("[TB] test_random done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1;
    drive(0, 0, 32'h0, 0);
    test_reset();
    test_boot();
    test_wait_states();
    test_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_reset_mid_hold();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
